lsq_issue_arbiter: RTL and testbench
====================================

Name: lsq_issue_arbiter

Overview:
- Sits directly downstream of the ISU credit manager.
- Consumes the per-entry credit grant vector (entry_can_execute) together with LSQ valid/channel state.
- For each of the 3 xbar channels, selects the oldest granted, not-yet-issued LSQ entry and presents its index on a registered valid/ready request port toward the xbar.
- Tracks a per-entry issued bit so that every granted entry is issued exactly once until it is deallocated.

Parameters:
- LSQ_SIZE, 16, number of LSQ entries; must be a power of 2, >= 4.
- LSQ_PTR_W, 4, log2(LSQ_SIZE); width of an entry index.
- NUM_CH, 3, number of xbar channels; fixed at 3 (channel id 2'd3 is illegal).

Ports:
- clk  in  1  single clock, all state on rising edge.
- rst  in  1  reset, asynchronous, active-high; one clock, no other clock domains.
- lsq_entry_vld  in  LSQ_SIZE  entry holds a live instruction.
- lsq_entry_channel_id  in  2*LSQ_SIZE  channel of entry i at bits [2i+1:2i].
- entry_can_execute  in  LSQ_SIZE  credit granted to entry i (from credit manager).
- lsq_btm_ptr  in  LSQ_PTR_W  index of the oldest LSQ entry.
- lsq_entry_dealloc  in  LSQ_SIZE  entry i retires this cycle; clears its issued bit.
- d_xbar_req_valid  out  NUM_CH  request valid, per channel.
- d_xbar_req_ready  in  NUM_CH  xbar accepts request, per channel.
- d_xbar_req_idx  out  NUM_CH*LSQ_PTR_W  LSQ index issued on channel c at [c*LSQ_PTR_W +: LSQ_PTR_W].
- entry_issued  out  LSQ_SIZE  entry has been loaded into a channel request register.

Behaviour:
- Reset (async, rst=1): d_xbar_req_valid=0, d_xbar_req_idx=0, entry_issued=0. State is held for the whole time rst is high. The first selection is evaluated in the first cycle after deassertion.
- Eligible(i, c) = lsq_entry_vld[i] & entry_can_execute[i] & ~entry_issued[i] & ~lsq_entry_dealloc[i] & (channel_id[i]==c).
- Age key(i) = (i - lsq_btm_ptr) mod LSQ_SIZE, computed in LSQ_PTR_W-bit wrap-around arithmetic. The smallest key is the oldest; keys are unique, so there are no ties.
- Per channel c, the output register is "free" when ~valid[c] | (valid[c] & ready[c]).
- If free and any eligible entry exists for c: load idx = oldest eligible, set valid[c]=1, set entry_issued[idx]=1.
- If free and no eligible entry exists: valid[c]=0 next cycle; idx[c] holds its last value.
- If not free (valid & ~ready): valid and idx hold stable; no new selection on c.
- Latency: an entry becoming eligible in cycle N appears with valid=1 in cycle N+1 if the channel register is free in N.
- Back-to-back: a handshake in cycle N plus another eligible entry gives valid=1 continuously with the new idx in N+1. Throughput is 1 request per channel per cycle.
- Channels are independent. Up to 3 loads per cycle, on distinct entries because channel ids differ.
- Issued-bit update per entry: set by a load; cleared by lsq_entry_dealloc[i]. If set and clear occur in the same cycle, clear wins. Set cannot occur in that case because a deallocating entry is ineligible.
- Deallocating an entry while it is held in a valid channel register is illegal (assertion). The LSQ only retires entries that the xbar has accepted.
- Entries with channel id 2'd3 are never selected (assertion flags it when vld=1).
- Wrap-around: the age key handles btm_ptr > idx. Example, LSQ_SIZE=16 and btm=14: order is 14, 15, 0, 1, …

Test Plan:
- Reset then single grant: entry 5, ch1, vld+can_execute in cycle 2 with ready=1 → valid[1]=1, idx[1]=5 in cycle 3; entry_issued[5]=1; entry 5 is never re-issued while can_execute stays 1.
- Oldest-first with wrap: btm=14, entries 15, 2 and 14 granted on ch0 simultaneously, ready=1 → idx[0] sequence 14, 15, 2 in consecutive cycles, then valid[0]=0.
- Backpressure: ch2 valid with idx=7 and ready=0 for 4 cycles while entry 9 is also granted → idx stays 7; ready=1 in cycle 5 → idx=9 in cycle 6 with no bubble.
- Parallel channels: entries 0/1/2 on ch0/1/2 all granted in the same cycle → all three valids assert together next cycle with idx 0, 1, 2.
- Dealloc/reuse: entry 3 issued, then dealloc[3] and re-alloc with a new grant → entry_issued[3] clears, then entry 3 is issued again on its new channel.
- Async reset mid-stream: rst pulsed high between clock edges while valid=3'b111 → outputs clear immediately (before the next edge); after deassertion, still-granted entries are re-issued oldest-first.

Source files
------------

// File: rtl/lsq_issue_arbiter.sv
// Per-channel oldest-first issue of granted LSQ entries into registered xbar requests.
// Latency: 1 cycle from eligibility to valid; a stalled channel (valid & ~ready) holds idx and selects nothing.
module lsq_issue_arbiter #(
  parameter int LSQ_SIZE  = 16,
  parameter int LSQ_PTR_W = 4,
  parameter int NUM_CH    = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [LSQ_SIZE-1:0]           lsq_entry_vld,
  input  logic [2*LSQ_SIZE-1:0]         lsq_entry_channel_id,
  input  logic [LSQ_SIZE-1:0]           entry_can_execute,
  input  logic [LSQ_PTR_W-1:0]          lsq_btm_ptr,
  input  logic [LSQ_SIZE-1:0]           lsq_entry_dealloc,
  output logic [NUM_CH-1:0]             d_xbar_req_valid,
  input  logic [NUM_CH-1:0]             d_xbar_req_ready,
  output logic [NUM_CH*LSQ_PTR_W-1:0]   d_xbar_req_idx,
  output logic [LSQ_SIZE-1:0]           entry_issued
);

  logic [NUM_CH-1:0][LSQ_SIZE-1:0] elig;
  logic [NUM_CH-1:0]               ch_free;
  logic [NUM_CH-1:0]               sel_vld;
  logic [NUM_CH*LSQ_PTR_W-1:0]     sel_idx;
  logic [LSQ_PTR_W-1:0]            scan_idx;
  logic [LSQ_SIZE-1:0]             issued_nxt;

  always_comb begin
    elig = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      for (int i = 0; i < LSQ_SIZE; i++) begin
        elig[c][i] = lsq_entry_vld[i] & entry_can_execute[i] & ~entry_issued[i] &
                     ~lsq_entry_dealloc[i] & (lsq_entry_channel_id[2*i +: 2] == 2'(c));
      end
    end
  end

  // Scan from youngest to oldest so the oldest eligible entry is the last to overwrite.
  always_comb begin
    ch_free  = ~d_xbar_req_valid | d_xbar_req_ready;
    sel_vld  = '0;
    sel_idx  = '0;
    scan_idx = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      for (int k = LSQ_SIZE - 1; k >= 0; k--) begin
        scan_idx = lsq_btm_ptr + LSQ_PTR_W'(k);
        if (elig[c][scan_idx]) begin
          sel_vld[c]                          = 1'b1;
          sel_idx[c*LSQ_PTR_W +: LSQ_PTR_W]   = scan_idx;
        end
      end
    end
  end

  // Dealloc is applied after loads so a same-cycle clear always wins.
  always_comb begin
    issued_nxt = entry_issued;
    for (int c = 0; c < NUM_CH; c++) begin
      if (ch_free[c] && sel_vld[c]) begin
        issued_nxt[sel_idx[c*LSQ_PTR_W +: LSQ_PTR_W]] = 1'b1;
      end
    end
    issued_nxt = issued_nxt & ~lsq_entry_dealloc;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_xbar_req_valid <= '0;
      d_xbar_req_idx   <= '0;
      entry_issued     <= '0;
    end else begin
      entry_issued <= issued_nxt;
      for (int c = 0; c < NUM_CH; c++) begin
        if (ch_free[c]) begin
          d_xbar_req_valid[c] <= sel_vld[c];
          if (sel_vld[c]) begin
            d_xbar_req_idx[c*LSQ_PTR_W +: LSQ_PTR_W] <= sel_idx[c*LSQ_PTR_W +: LSQ_PTR_W];
          end
        end
      end
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch_chk
    a_no_dealloc_while_held: assert property (@(posedge clk) disable iff (rst)
      !(d_xbar_req_valid[c] && lsq_entry_dealloc[d_xbar_req_idx[c*LSQ_PTR_W +: LSQ_PTR_W]]));
  end

  for (genvar i = 0; i < LSQ_SIZE; i++) begin : g_ent_chk
    a_no_illegal_channel: assert property (@(posedge clk) disable iff (rst)
      !(lsq_entry_vld[i] && (lsq_entry_channel_id[2*i +: 2] == 2'd3)));
  end

endmodule

// File: tb/tb_lsq_issue_arbiter.sv
// Bench for lsq_issue_arbiter: single-cycle vector table plus multi-cycle sequences with a per-channel idx scoreboard.
module tb_lsq_issue_arbiter;
  localparam int N = 16;
  localparam int W = 4;
  localparam int C = 3;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   lsq_entry_vld;
  logic [2*N-1:0] lsq_entry_channel_id;
  logic [N-1:0]   entry_can_execute;
  logic [W-1:0]   lsq_btm_ptr;
  logic [N-1:0]   lsq_entry_dealloc;
  logic [C-1:0]   d_xbar_req_valid;
  logic [C-1:0]   d_xbar_req_ready;
  logic [C*W-1:0] d_xbar_req_idx;
  logic [N-1:0]   entry_issued;

  lsq_issue_arbiter #(.LSQ_SIZE(N), .LSQ_PTR_W(W), .NUM_CH(C)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .lsq_entry_vld        (lsq_entry_vld),
    .lsq_entry_channel_id (lsq_entry_channel_id),
    .entry_can_execute    (entry_can_execute),
    .lsq_btm_ptr          (lsq_btm_ptr),
    .lsq_entry_dealloc    (lsq_entry_dealloc),
    .d_xbar_req_valid     (d_xbar_req_valid),
    .d_xbar_req_ready     (d_xbar_req_ready),
    .d_xbar_req_idx       (d_xbar_req_idx),
    .entry_issued         (entry_issued)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0]   vld;
    logic [2*N-1:0] chan;
    logic [N-1:0]   can;
    logic [W-1:0]   btm;
    logic [N-1:0]   dealloc;
    logic [C-1:0]   exp_valid;
    logic [C*W-1:0] exp_idx;
    logic [N-1:0]   exp_issued;
  } vec_t;

  vec_t tbl[10];
  int   checks = 0;
  int   errors = 0;
  int   q0[$];
  int   q1[$];
  int   q2[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic push(input int c, input int v);
    case (c)
      0: q0.push_back(v);
      1: q1.push_back(v);
      default: q2.push_back(v);
    endcase
  endtask

  // Pops the expected idx for every channel handshaking this cycle.
  task automatic sb_check();
    int have;
    int exp;
    for (int c = 0; c < C; c++) begin
      if (d_xbar_req_valid[c] && d_xbar_req_ready[c]) begin
        have = 0;
        exp  = 0;
        case (c)
          0: begin have = q0.size(); if (have > 0) exp = q0.pop_front(); end
          1: begin have = q1.size(); if (have > 0) exp = q1.pop_front(); end
          default: begin have = q2.size(); if (have > 0) exp = q2.pop_front(); end
        endcase
        if (have == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_ch%0d unexpected handshake idx=%0d required=none", c,
                   d_xbar_req_idx[c*W +: W]);
        end else begin
          chk($sformatf("sb_ch%0d", c), 32'(d_xbar_req_idx[c*W +: W]), 32'(exp));
        end
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    sb_check();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [N-1:0] vld, input logic [2*N-1:0] chan, input logic [N-1:0] can,
                        input logic [W-1:0] btm, input logic [N-1:0] dealloc, input logic [C-1:0] rdy);
    lsq_entry_vld        = vld;
    lsq_entry_channel_id = chan;
    entry_can_execute    = can;
    lsq_btm_ptr          = btm;
    lsq_entry_dealloc    = dealloc;
    d_xbar_req_ready     = rdy;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    set_in('0, '0, '0, '0, '0, '0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    set_in('0, '0, '0, '0, '0, '0);
    #1;
    chk("reset_valid", 32'(d_xbar_req_valid), 32'h0);
    chk("reset_idx", 32'(d_xbar_req_idx), 32'h0);
    chk("reset_issued", 32'(entry_issued), 32'h0);

    tbl[0] = '{vld:16'h0000, chan:32'h0,        can:16'h0000, btm:4'd0,  dealloc:16'h0,    exp_valid:3'b000, exp_idx:12'h000, exp_issued:16'h0000};
    tbl[1] = '{vld:16'h0020, chan:32'h400,      can:16'h0020, btm:4'd0,  dealloc:16'h0,    exp_valid:3'b010, exp_idx:12'h050, exp_issued:16'h0020};
    tbl[2] = '{vld:16'h0007, chan:32'h24,       can:16'h0007, btm:4'd0,  dealloc:16'h0,    exp_valid:3'b111, exp_idx:12'h210, exp_issued:16'h0007};
    tbl[3] = '{vld:16'hC004, chan:32'h0,        can:16'hC004, btm:4'd14, dealloc:16'h0,    exp_valid:3'b001, exp_idx:12'h00E, exp_issued:16'h4000};
    tbl[4] = '{vld:16'h00FF, chan:32'h0,        can:16'h0000, btm:4'd0,  dealloc:16'h0,    exp_valid:3'b000, exp_idx:12'h000, exp_issued:16'h0000};
    tbl[5] = '{vld:16'h0000, chan:32'h0,        can:16'h00FF, btm:4'd0,  dealloc:16'h0,    exp_valid:3'b000, exp_idx:12'h000, exp_issued:16'h0000};
    tbl[6] = '{vld:16'h0280, chan:32'h00088000, can:16'h0280, btm:4'd8,  dealloc:16'h0,    exp_valid:3'b100, exp_idx:12'h900, exp_issued:16'h0200};
    tbl[7] = '{vld:16'h8008, chan:32'h40000040, can:16'h8008, btm:4'd0,  dealloc:16'h0,    exp_valid:3'b010, exp_idx:12'h030, exp_issued:16'h0008};
    tbl[8] = '{vld:16'h006C, chan:32'h2020,     can:16'h006C, btm:4'd4,  dealloc:16'h0,    exp_valid:3'b101, exp_idx:12'h605, exp_issued:16'h0060};
    tbl[9] = '{vld:16'h0110, chan:32'h0,        can:16'h0110, btm:4'd0,  dealloc:16'h0010, exp_valid:3'b001, exp_idx:12'h008, exp_issued:16'h0100};

    for (int v = 0; v < 10; v++) begin
      do_reset();
      set_in(tbl[v].vld, tbl[v].chan, tbl[v].can, tbl[v].btm, tbl[v].dealloc, 3'b000);
      step();
      chk($sformatf("vec%0d_valid", v), 32'(d_xbar_req_valid), 32'(tbl[v].exp_valid));
      chk($sformatf("vec%0d_idx", v), 32'(d_xbar_req_idx), 32'(tbl[v].exp_idx));
      chk($sformatf("vec%0d_issued", v), 32'(entry_issued), 32'(tbl[v].exp_issued));
    end

    // Single grant, never re-issued while the grant persists.
    do_reset();
    set_in(16'h0020, 32'h400, 16'h0020, 4'd0, '0, 3'b111);
    push(1, 5);
    step();
    chk("single_valid", 32'(d_xbar_req_valid), 32'b010);
    chk("single_idx1", 32'(d_xbar_req_idx[7:4]), 32'd5);
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("single_noreissue%0d", k), 32'(d_xbar_req_valid), 32'b000);
      chk($sformatf("single_issued%0d", k), 32'(entry_issued), 32'h0020);
    end

    // Oldest-first with wrap-around.
    do_reset();
    set_in(16'hC004, 32'h0, 16'hC004, 4'd14, '0, 3'b111);
    push(0, 14); push(0, 15); push(0, 2);
    step();
    chk("wrap_v0", 32'(d_xbar_req_valid), 32'b001);
    chk("wrap_i0", 32'(d_xbar_req_idx[3:0]), 32'd14);
    step();
    chk("wrap_v1", 32'(d_xbar_req_valid), 32'b001);
    chk("wrap_i1", 32'(d_xbar_req_idx[3:0]), 32'd15);
    step();
    chk("wrap_v2", 32'(d_xbar_req_valid), 32'b001);
    chk("wrap_i2", 32'(d_xbar_req_idx[3:0]), 32'd2);
    step();
    chk("wrap_done", 32'(d_xbar_req_valid), 32'b000);
    chk("wrap_idx_hold", 32'(d_xbar_req_idx[3:0]), 32'd2);

    // Backpressure on ch2, then back-to-back issue.
    do_reset();
    set_in(16'h0280, 32'h00088000, 16'h0280, 4'd0, '0, 3'b000);
    push(2, 7); push(2, 9);
    step();
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("bp_hold_v%0d", k), 32'(d_xbar_req_valid), 32'b100);
      chk($sformatf("bp_hold_i%0d", k), 32'(d_xbar_req_idx[11:8]), 32'd7);
      if (k < 3) step();
    end
    chk("bp_issued_hold", 32'(entry_issued), 32'h0080);
    d_xbar_req_ready = 3'b100;
    step();
    chk("bp_b2b_v", 32'(d_xbar_req_valid), 32'b100);
    chk("bp_b2b_i", 32'(d_xbar_req_idx[11:8]), 32'd9);
    step();
    chk("bp_done", 32'(d_xbar_req_valid), 32'b000);

    // Dealloc clears issued bit, then reuse on a new channel.
    do_reset();
    set_in(16'h0008, 32'h0, 16'h0008, 4'd0, '0, 3'b111);
    push(0, 3);
    step();
    chk("reuse_v0", 32'(d_xbar_req_valid), 32'b001);
    chk("reuse_i0", 32'(d_xbar_req_idx[3:0]), 32'd3);
    step();
    chk("reuse_v_idle", 32'(d_xbar_req_valid), 32'b000);
    chk("reuse_issued_set", 32'(entry_issued), 32'h0008);
    lsq_entry_dealloc = 16'h0008;
    step();
    chk("reuse_issued_clr", 32'(entry_issued), 32'h0000);
    chk("reuse_v_dealloc", 32'(d_xbar_req_valid), 32'b000);
    lsq_entry_dealloc    = '0;
    lsq_entry_channel_id = 32'h80;
    push(2, 3);
    step();
    chk("reuse_v2", 32'(d_xbar_req_valid), 32'b100);
    chk("reuse_i2", 32'(d_xbar_req_idx[11:8]), 32'd3);
    chk("reuse_issued_again", 32'(entry_issued), 32'h0008);
    step();

    // Async reset between edges while all channels are valid.
    do_reset();
    set_in(16'h0077, 32'h2424, 16'h0077, 4'd0, '0, 3'b000);
    step();
    chk("arst_pre_v", 32'(d_xbar_req_valid), 32'b111);
    chk("arst_pre_i", 32'(d_xbar_req_idx), 32'h210);
    #1 rst = 1'b1;
    #1;
    chk("arst_v", 32'(d_xbar_req_valid), 32'b000);
    chk("arst_i", 32'(d_xbar_req_idx), 32'h000);
    chk("arst_issued", 32'(entry_issued), 32'h0000);
    #1;
    rst = 1'b0;
    lsq_btm_ptr      = 4'd1;
    d_xbar_req_ready = 3'b111;
    push(0, 4); push(0, 0);
    push(1, 1); push(1, 5);
    push(2, 2); push(2, 6);
    step();
    chk("arst_re1_v", 32'(d_xbar_req_valid), 32'b111);
    chk("arst_re1_i", 32'(d_xbar_req_idx), 32'h214);
    step();
    chk("arst_re2_v", 32'(d_xbar_req_valid), 32'b111);
    chk("arst_re2_i", 32'(d_xbar_req_idx), 32'h650);
    step();
    chk("arst_re_done", 32'(d_xbar_req_valid), 32'b000);

    chk("sb_drain_ch0", 32'(q0.size()), 32'd0);
    chk("sb_drain_ch1", 32'(q1.size()), 32'd0);
    chk("sb_drain_ch2", 32'(q2.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
